elbeth_hazard_ctrl: RTL and testbench

Parametrised pipeline-control successor for ELBETH. It generalises stall/flush generation to NUM_STAGES stages and resolves memory waits through a state machine with a timeout. Timeouts raise bus-error exceptions, and a load-use interlock inserts a bubble. ERET drain length is configurable, and the block keeps an instret counter. It sits beside the decode control unit and drives the PC mux and every pipeline register's stall/flush.

---
 rtl/elbeth_hazard_ctrl_pkg.sv | 26 ++
 rtl/elbeth_hazard_ctrl_instret.sv | 19 +
 rtl/elbeth_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_elbeth_hazard_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/elbeth_hazard_ctrl_pkg.sv
// Shared ELBETH pipeline-control definitions: FSM encodings, PC mux selects
// and bus-error exception codes used by the hazard controller and downstream.
package elbeth_hazard_ctrl_pkg;

    typedef logic [1:0] hz_state_t;
    typedef logic [1:0] pc_sel_t;

    localparam hz_state_t ST_RUN   = 2'd0;
    localparam hz_state_t ST_IWAIT = 2'd1;
    localparam hz_state_t ST_DWAIT = 2'd2;
    localparam hz_state_t ST_ERET  = 2'd3;

    localparam pc_sel_t PC_SEL_NEXT   = 2'd0;
    localparam pc_sel_t PC_SEL_BRANCH = 2'd1;
    localparam pc_sel_t PC_SEL_EXCEPT = 2'd2;
    localparam pc_sel_t PC_SEL_EPC    = 2'd3;

    // Cause codes reported by the exception unit when a timeout fires.
    localparam logic [4:0] ECODE_IBUS_ERR = 5'd6;
    localparam logic [4:0] ECODE_DBUS_ERR = 5'd7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elbeth_hazard_ctrl_instret.sv
// Retired-instruction counter: increments on each retire, wraps naturally.
module elbeth_instret_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/elbeth_hazard_ctrl.sv
// ELBETH hazard controller: stall/flush generation, memory-wait FSM with
// bus-error timeout, ERET drain and instret counting.
module elbeth_hazard_ctrl
    import elbeth_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 3,
    parameter int MEM_TIMEOUT  = 16,
    parameter int ERET_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_imem_en,
    input  logic                  if_imem_ready,
    input  logic                  exs_dmem_en,
    input  logic                  exs_dmem_ready,
    input  logic                  id_branch_taken,
    input  logic                  id_load_use,
    input  logic                  exs_except,
    input  logic                  exs_eret,
    input  logic                  exs_valid,
    output logic                  pc_stall,
    output logic [NUM_STAGES-1:0] stage_stall,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic [1:0]            pc_select,
    output logic                  imem_timeout,
    output logic                  dmem_timeout,
    output logic                  exs_retire,
    output logic [CNT_W-1:0]      instret
);

    // The counter must reach MEM_TIMEOUT-1 and ERET_BUBBLES.
    localparam int WCNT_W = $clog2(max_int(MEM_TIMEOUT, ERET_BUBBLES + 1));

    localparam logic [WCNT_W-1:0]     WCNT_ONE     = WCNT_W'(1);
    localparam logic [WCNT_W-1:0]     WCNT_TIMEOUT = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0]     WCNT_ERET    = WCNT_W'(ERET_BUBBLES);
    localparam logic [NUM_STAGES-1:0] ALL_STAGES   = '1;
    localparam logic [NUM_STAGES-1:0] FRONT_STAGES = {1'b0, {(NUM_STAGES-1){1'b1}}};
    localparam logic [NUM_STAGES-1:0] STAGE_IFID   = NUM_STAGES'(1);
    localparam logic [NUM_STAGES-1:0] STAGE_IDEX   = NUM_STAGES'(2);

    hz_state_t             state, state_nxt;
    logic [WCNT_W-1:0]     wcnt, wcnt_nxt;
    logic                  dmem_wait, imem_wait;
    logic                  pc_stall_c, timeout_flush, ito_c, dto_c;
    logic [NUM_STAGES-1:0] stall_c, flush_c;
    pc_sel_t               sel_c;

    assign dmem_wait = exs_dmem_en & ~exs_dmem_ready;
    assign imem_wait = if_imem_en & ~if_imem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        pc_stall_c    = 1'b0;
        stall_c       = '0;
        flush_c       = '0;
        sel_c         = PC_SEL_NEXT;
        ito_c         = 1'b0;
        dto_c         = 1'b0;
        timeout_flush = 1'b0;
        case (state)
            ST_RUN: begin
                if (dmem_wait) begin
                    pc_stall_c = 1'b1;
                    stall_c    = ALL_STAGES;
                    state_nxt  = ST_DWAIT;
                    wcnt_nxt   = WCNT_ONE;
                end else if (exs_except) begin
                    sel_c   = PC_SEL_EXCEPT;
                    flush_c = FRONT_STAGES;
                end else if (exs_eret) begin
                    sel_c     = PC_SEL_EPC;
                    flush_c   = FRONT_STAGES;
                    state_nxt = ST_ERET;
                    wcnt_nxt  = WCNT_ONE;
                end else if (imem_wait) begin
                    pc_stall_c = 1'b1;
                    stall_c    = ALL_STAGES;
                    state_nxt  = ST_IWAIT;
                    wcnt_nxt   = WCNT_ONE;
                end else if (id_load_use) begin
                    pc_stall_c = 1'b1;
                    stall_c    = STAGE_IFID;
                    flush_c    = STAGE_IDEX;
                end else if (id_branch_taken) begin
                    sel_c   = PC_SEL_BRANCH;
                    flush_c = STAGE_IFID;
                end
            end
            ST_DWAIT: begin
                if (exs_dmem_ready) begin
                    state_nxt = ST_RUN;
                    wcnt_nxt  = '0;
                end else if (wcnt == WCNT_TIMEOUT) begin
                    dto_c         = 1'b1;
                    sel_c         = PC_SEL_EXCEPT;
                    flush_c       = ALL_STAGES;
                    timeout_flush = 1'b1;
                    state_nxt     = ST_RUN;
                    wcnt_nxt      = '0;
                end else begin
                    pc_stall_c = 1'b1;
                    stall_c    = ALL_STAGES;
                    wcnt_nxt   = wcnt + WCNT_ONE;
                end
            end
            // A trap or eret reaching EXS abandons the outstanding fetch.
            ST_IWAIT: begin
                if (exs_except) begin
                    sel_c     = PC_SEL_EXCEPT;
                    flush_c   = FRONT_STAGES;
                    state_nxt = ST_RUN;
                    wcnt_nxt  = '0;
                end else if (exs_eret) begin
                    sel_c     = PC_SEL_EPC;
                    flush_c   = FRONT_STAGES;
                    state_nxt = ST_ERET;
                    wcnt_nxt  = WCNT_ONE;
                end else if (if_imem_ready) begin
                    state_nxt = ST_RUN;
                    wcnt_nxt  = '0;
                end else if (wcnt == WCNT_TIMEOUT) begin
                    ito_c         = 1'b1;
                    sel_c         = PC_SEL_EXCEPT;
                    flush_c       = FRONT_STAGES;
                    timeout_flush = 1'b1;
                    state_nxt     = ST_RUN;
                    wcnt_nxt      = '0;
                end else begin
                    pc_stall_c = 1'b1;
                    stall_c    = ALL_STAGES;
                    wcnt_nxt   = wcnt + WCNT_ONE;
                end
            end
            ST_ERET: begin
                pc_stall_c = 1'b1;
                stall_c    = ALL_STAGES;
                if (wcnt == WCNT_ERET) begin
                    state_nxt = ST_RUN;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt = wcnt + WCNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                wcnt_nxt  = '0;
            end
        endcase
    end

    // Reset holds the whole pipe; a held register ignores a normal flush.
    assign pc_stall     = rst | pc_stall_c;
    assign stage_stall  = rst ? ALL_STAGES : stall_c;
    assign stage_flush  = rst ? '0 : (timeout_flush ? flush_c : (flush_c & ~stall_c));
    assign pc_select    = rst ? PC_SEL_NEXT : sel_c;
    assign imem_timeout = ~rst & ito_c;
    assign dmem_timeout = ~rst & dto_c;
    assign exs_retire   = exs_valid & (state == ST_RUN) & ~dmem_wait & ~exs_except & ~rst;

    elbeth_instret_counter #(
        .CNT_W(CNT_W)
    ) u_instret (
        .clk  (clk),
        .rst  (rst),
        .en   (exs_retire),
        .count(instret)
    );

endmodule

// File: tb/tb_elbeth_hazard_ctrl.sv
// Scoreboard bench for elbeth_hazard_ctrl: directed vectors push expected
// outputs, a negedge monitor pops and compares them.
module tb_elbeth_hazard_ctrl;

    localparam int NS = 3;
    localparam int MT = 16;
    localparam int EB = 2;
    localparam int CW = 4;

    // Stimulus bit order: rst imEn imRdy dmEn dmRdy br lu exc eret valid
    localparam logic [9:0] IDLE = 10'b0_1_1_0_0_0_0_0_0_0;
    localparam logic [9:0] RETI = 10'b0_1_1_0_0_0_0_0_0_1;

    logic          clk = 1'b0;
    logic          rst, if_imem_en, if_imem_ready, exs_dmem_en, exs_dmem_ready;
    logic          id_branch_taken, id_load_use, exs_except, exs_eret, exs_valid;
    logic          pc_stall, imem_timeout, dmem_timeout, exs_retire;
    logic [NS-1:0] stage_stall, stage_flush;
    logic [1:0]    pc_select;
    logic [CW-1:0] instret;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t          scoreboard[$];
    int            vectorCount = 0;
    int            missCount   = 0;
    logic [CW-1:0] modelInstret = '0;

    always #5 clk = ~clk;

    elbeth_hazard_ctrl #(
        .NUM_STAGES(NS), .MEM_TIMEOUT(MT), .ERET_BUBBLES(EB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .if_imem_en(if_imem_en), .if_imem_ready(if_imem_ready),
        .exs_dmem_en(exs_dmem_en), .exs_dmem_ready(exs_dmem_ready),
        .id_branch_taken(id_branch_taken), .id_load_use(id_load_use),
        .exs_except(exs_except), .exs_eret(exs_eret), .exs_valid(exs_valid),
        .pc_stall(pc_stall), .stage_stall(stage_stall), .stage_flush(stage_flush),
        .pc_select(pc_select), .imem_timeout(imem_timeout), .dmem_timeout(dmem_timeout),
        .exs_retire(exs_retire), .instret(instret)
    );

    task automatic applyStimulus(input string name, input logic [9:0] in,
                                 input logic expPc, input logic [2:0] expStall,
                                 input logic [2:0] expFlush, input logic [1:0] expSel,
                                 input logic expIto, input logic expDto, input logic expRet);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, if_imem_en, if_imem_ready, exs_dmem_en, exs_dmem_ready,
         id_branch_taken, id_load_use, exs_except, exs_eret, exs_valid} = in;
        if (in[9]) modelInstret = '0;
        e.name = name;
        e.exp  = {expPc, expStall, expFlush, expSel, expIto, expDto, expRet, modelInstret};
        scoreboard.push_back(e);
        if (expRet) modelInstret = modelInstret + 1'b1;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [15:0] act;
        e   = scoreboard.pop_front();
        act = {pc_stall, stage_stall, stage_flush, pc_select,
               imem_timeout, dmem_timeout, exs_retire, instret};
        vectorCount++;
        if (act !== e.exp) begin
            missCount++;
            $display("[TB] FAIL %s: got pcst=%b st=%b fl=%b sel=%0d ito=%b dto=%b ret=%b ir=%0d, expected %b_%b_%b_%b_%b_%b_%b_%b",
                     e.name, act[15], act[14:12], act[11:9], act[8:7], act[6], act[5], act[4], act[3:0],
                     e.exp[15], e.exp[14:12], e.exp[11:9], e.exp[8:7], e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
        end
    endtask

    always @(negedge clk) begin
        if (scoreboard.size() > 0) checkOutput();
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        {rst, if_imem_en, if_imem_ready, exs_dmem_en, exs_dmem_ready,
         id_branch_taken, id_load_use, exs_except, exs_eret, exs_valid} = 10'b1_0_1_0_0_0_0_0_0_0;

        for (int i = 0; i < 3; i++)
            applyStimulus("reset", 10'b1_0_1_0_0_0_0_0_0_0, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("run_idle", IDLE, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("retire", RETI, 0, 3'b000, 3'b000, 2'd0, 0, 0, 1);

        for (int i = 0; i < 4; i++)
            applyStimulus("dwait_stall", 10'b0_1_1_1_0_0_0_0_0_1, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("dwait_ready", 10'b0_1_1_1_1_0_0_0_0_1, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("dwait_retire", RETI, 0, 3'b000, 3'b000, 2'd0, 0, 0, 1);

        for (int i = 0; i < MT - 1; i++)
            applyStimulus("dto_stall", 10'b0_1_1_1_0_0_0_0_0_0, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("dmem_timeout", 10'b0_1_1_1_0_0_0_0_0_0, 0, 3'b000, 3'b111, 2'd2, 0, 1, 0);
        applyStimulus("post_dto", IDLE, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);

        applyStimulus("eret", 10'b0_1_1_0_0_0_0_0_1_1, 0, 3'b000, 3'b011, 2'd3, 0, 0, 1);
        for (int i = 0; i < EB; i++)
            applyStimulus("eret_drain", IDLE, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("post_eret", IDLE, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);

        applyStimulus("lu_branch", 10'b0_1_1_0_0_1_1_0_0_0, 1, 3'b001, 3'b010, 2'd0, 0, 0, 0);
        applyStimulus("branch", 10'b0_1_1_0_0_1_0_0_0_0, 0, 3'b000, 3'b001, 2'd1, 0, 0, 0);
        applyStimulus("except", 10'b0_1_1_0_0_0_0_1_0_1, 0, 3'b000, 3'b011, 2'd2, 0, 0, 0);
        applyStimulus("except_eret", 10'b0_1_1_0_0_0_0_1_1_0, 0, 3'b000, 3'b011, 2'd2, 0, 0, 0);
        applyStimulus("dmem_over_exc", 10'b0_1_1_1_0_0_0_1_0_1, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("dwait_ready2", 10'b0_1_1_1_1_0_0_0_0_0, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);

        applyStimulus("iwait_enter", 10'b0_1_0_0_0_0_0_0_0_0, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("iwait_stall", 10'b0_1_0_0_0_0_0_0_0_0, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("iwait_except", 10'b0_1_0_0_0_0_0_1_0_0, 0, 3'b000, 3'b011, 2'd2, 0, 0, 0);
        applyStimulus("post_iexc", IDLE, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);

        for (int i = 0; i < MT - 1; i++)
            applyStimulus("ito_stall", 10'b0_1_0_0_0_0_0_0_0_0, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("imem_timeout", 10'b0_1_0_0_0_0_0_0_0_0, 0, 3'b000, 3'b011, 2'd2, 1, 0, 0);
        applyStimulus("post_ito", IDLE, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);

        applyStimulus("iwait_enter2", 10'b0_1_0_0_0_0_0_0_0_0, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("iwait_eret", 10'b0_1_0_0_0_0_0_0_1_0, 0, 3'b000, 3'b011, 2'd3, 0, 0, 0);
        for (int i = 0; i < EB; i++)
            applyStimulus("ieret_drain", IDLE, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("post_ieret", IDLE, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);

        for (int i = 0; i < (1 << CW); i++)
            applyStimulus("wrap_retire", RETI, 0, 3'b000, 3'b000, 2'd0, 0, 0, 1);
        applyStimulus("post_wrap", IDLE, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("reset2", 10'b1_1_1_0_0_1_0_0_0_1, 1, 3'b111, 3'b000, 2'd0, 0, 0, 0);
        applyStimulus("after_reset2", IDLE, 0, 3'b000, 3'b000, 2'd0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (scoreboard.size() != 0) begin
            missCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
